// File: rtl/button_conditioner_if.sv
// Board-side bundle for button_conditioner: raw inputs in, conditioned outputs out.
// master drives the raw inputs, slave is the conditioner.
interface button_conditioner_if;
  logic add_in;
  logic deduct_in;
  logic mode_in;
  logic add_pls;
  logic deduct_pls;
  logic mode_out;

  modport master (
    output add_in, deduct_in, mode_in,
    input  add_pls, deduct_pls, mode_out
  );

  modport slave (
    input  add_in, deduct_in, mode_in,
    output add_pls, deduct_pls, mode_out
  );
endinterface

// File: rtl/button_conditioner.sv
// Sync + debounce + press pulses with interlock for add/deduct, level for mode.
// Define AUTO_REPEAT_EN to auto-repeat pulses while a button stays held.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 64,
  parameter int REPEAT_PERIOD   = 16,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic reset,
  button_conditioner_if.slave bus
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] PRESS    = 3'd1;
  localparam logic [2:0] HELD     = 3'd2;
  localparam logic [2:0] REPEAT   = 3'd3;
  localparam logic [2:0] SUPPRESS = 3'd4;

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  // bit 0 add, bit 1 deduct, bit 2 mode
  localparam logic [2:0] RELEASED = 3'b011;

  logic [2:0]       raw;
  logic [2:0]       sync1;
  logic [2:0]       sync2;
  logic [2:0]       stable;
  logic [2:0]       accept;
  logic [CNT_W-1:0] db_cnt [3];

  logic [1:0] press;
  logic [1:0] rel;
  logic [1:0] other_down;
  logic [1:0] blocked;
  logic [1:0] fire;
  logic [1:0] pls;
  logic [2:0] state    [2];
  logic [2:0] state_nx [2];

`ifdef AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);
  logic [CNT_W-1:0] hold    [2];
  logic [CNT_W-1:0] hold_nx [2];
`else
  logic unused_cfg;
  assign unused_cfg = ^{32'(REPEAT_DELAY), 32'(REPEAT_PERIOD)};
`endif

  assign raw = {bus.mode_in, bus.deduct_in, bus.add_in};

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      accept[i] = (sync2[i] != stable[i]) &&
                  (db_cnt[i] == DB_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1  <= RELEASED;
      sync2  <= RELEASED;
      stable <= RELEASED;
      for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (accept[i]) begin
          stable[i] <= sync2[i];
          db_cnt[i] <= '0;
        end else if (db_cnt[i] != CNT_MAX) begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign press      = accept[1:0] & stable[1:0];
  assign rel        = accept[1:0] & ~stable[1:0];
  assign other_down = ~{stable[0], stable[1]};
  // simultaneous acceptance blocks both buttons
  assign blocked    = other_down | {press[0], press[1]};

  always_comb begin
    for (int b = 0; b < 2; b++) begin
      fire[b]     = 1'b0;
      state_nx[b] = state[b];
`ifdef AUTO_REPEAT_EN
      hold_nx[b]  = hold[b];
`endif
      unique case (state[b])
        IDLE: begin
          if (press[b]) begin
            if (blocked[b]) begin
              state_nx[b] = SUPPRESS;
            end else begin
              state_nx[b] = PRESS;
              fire[b]     = 1'b1;
`ifdef AUTO_REPEAT_EN
              hold_nx[b]  = '0;
`endif
            end
          end
        end
        PRESS, HELD, REPEAT: begin
          if (rel[b]) begin
            state_nx[b] = IDLE;
          end else if (other_down[b]) begin
            state_nx[b] = SUPPRESS;
          end else begin
`ifdef AUTO_REPEAT_EN
            if (hold[b] == ((state[b] == REPEAT) ?
                            PERIOD_LAST : DELAY_LAST)) begin
              fire[b]     = 1'b1;
              hold_nx[b]  = '0;
              state_nx[b] = REPEAT;
            end else begin
              state_nx[b] = (state[b] == REPEAT) ? REPEAT : HELD;
              if (hold[b] != CNT_MAX) hold_nx[b] = hold[b] + 1'b1;
            end
`else
            state_nx[b] = HELD;
`endif
          end
        end
        SUPPRESS: begin
          if (rel[b]) state_nx[b] = IDLE;
        end
        default: state_nx[b] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state[0] <= IDLE;
      state[1] <= IDLE;
      pls      <= 2'b11;
`ifdef AUTO_REPEAT_EN
      hold[0]  <= '0;
      hold[1]  <= '0;
`endif
    end else begin
      state[0] <= state_nx[0];
      state[1] <= state_nx[1];
      pls      <= ~fire;
`ifdef AUTO_REPEAT_EN
      hold[0]  <= hold_nx[0];
      hold[1]  <= hold_nx[1];
`endif
    end
  end

  assign bus.add_pls    = pls[0];
  assign bus.deduct_pls = pls[1];
  assign bus.mode_out   = stable[2];

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios then random bouncing inputs,
// compared every cycle with a lookback model of debounce, pulses and interlock.
module tb_button_conditioner;

  localparam int DC   = 4;
  localparam int RD   = 8;
  localparam int RP   = 3;
  localparam int MAXC = 4096;
`ifdef AUTO_REPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;

  button_conditioner_if bus ();

  button_conditioner #(
    .DEBOUNCE_CYCLES(DC),
    .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model state
  int       t = 0;
  bit       rst_h  [MAXC];
  bit       raw_h  [3][MAXC];
  bit       seen_h [3][MAXC];
  bit [2:0] m_st;
  int       last_flip [3];
  bit       act  [2];
  int       nrep [2];
  bit [1:0] epls;

  // observed pulse statistics
  int n_add, n_ded, first_add, first_ded;

  task automatic chk(input string tag, input int got, input int want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask

  task automatic clr_stats();
    n_add = 0;
    n_ded = 0;
    first_add = -1;
    first_ded = -1;
  endtask

  task automatic step(input bit a, input bit d, input bit m, input bit r);
    bit [2:0] relv;
    bit [2:0] rawv;
    bit [2:0] acc;
    bit [1:0] pr;
    bit [1:0] rl;
    bit [1:0] fire;
    int o;
    relv = 3'b011;
    rawv = {m, d, a};
    bus.add_in    = a;
    bus.deduct_in = d;
    bus.mode_in   = m;
    reset         = r;
    @(posedge clk);
    rst_h[t] = r;
    for (int i = 0; i < 3; i++) raw_h[i][t] = rawv[i];
    fire = 2'b00;
    acc  = 3'b000;
    if (!r) begin
      m_st = relv;
      for (int i = 0; i < 3; i++) last_flip[i] = t;
      act[0] = 1'b0;
      act[1] = 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        seen_h[i][t] = (t < 2 || !rst_h[t-1] || !rst_h[t-2]) ?
                       relv[i] : raw_h[i][t-2];
        // a flip needs DC consecutive differing samples since the last flip
        acc[i] = (t - last_flip[i] >= DC);
        if (acc[i]) begin
          for (int k = 0; k < DC; k++)
            if (seen_h[i][t-k] == m_st[i]) acc[i] = 1'b0;
        end
      end
      pr = acc[1:0] & m_st[1:0];
      rl = acc[1:0] & ~m_st[1:0];
      for (int b = 0; b < 2; b++) begin
        o = 1 - b;
        if (pr[b]) begin
          if (!m_st[o] || pr[o]) begin
            act[b] = 1'b0;
          end else begin
            act[b]  = 1'b1;
            fire[b] = 1'b1;
            nrep[b] = t + RD;
          end
        end else if (rl[b]) begin
          act[b] = 1'b0;
        end else if (act[b]) begin
          if (!m_st[o]) begin
            act[b] = 1'b0;
          end else if (AR && t == nrep[b]) begin
            fire[b] = 1'b1;
            nrep[b] = t + RP;
          end
        end
      end
      for (int i = 0; i < 3; i++) begin
        if (acc[i]) begin
          m_st[i] = ~m_st[i];
          last_flip[i] = t;
        end
      end
    end
    epls = ~fire;
    @(negedge clk);
    checks++;
    assert (bus.add_pls === epls[0]) else begin
      errors++;
      $error("FAIL add_pls t=%0d: got %b want %b", t, bus.add_pls, epls[0]);
    end
    checks++;
    assert (bus.deduct_pls === epls[1]) else begin
      errors++;
      $error("FAIL deduct_pls t=%0d: got %b want %b",
             t, bus.deduct_pls, epls[1]);
    end
    checks++;
    assert (bus.mode_out === m_st[2]) else begin
      errors++;
      $error("FAIL mode_out t=%0d: got %b want %b", t, bus.mode_out, m_st[2]);
    end
    checks++;
    assert ((bus.add_pls | bus.deduct_pls) === 1'b1) else begin
      errors++;
      $error("FAIL both_low t=%0d: got %b%b want not both 0",
             t, bus.add_pls, bus.deduct_pls);
    end
    if (bus.add_pls === 1'b0) begin
      if (first_add < 0) first_add = t;
      n_add++;
    end
    if (bus.deduct_pls === 1'b0) begin
      if (first_ded < 0) first_ded = t;
      n_ded++;
    end
    t++;
  endtask

  initial begin
    int p;
    int rr;
    int run [3];
    bit cur [3];

    // reset with idle inputs
    clr_stats();
    repeat (3) step(1, 1, 0, 0);
    repeat (4) step(1, 1, 0, 1);
    chk("reset_pulses", n_add + n_ded, 0);

    // single add press, 20 cycles
    clr_stats();
    p = t;
    repeat (20) step(0, 1, 0, 1);
    repeat (12) step(1, 1, 0, 1);
    chk("add_first_edge", first_add - p, 5);
    chk("add_count", n_add, AR ? 5 : 1);

    // short deduct glitch, then bouncing press
    clr_stats();
    repeat (3) step(1, 0, 0, 1);
    repeat (10) step(1, 1, 0, 1);
    chk("glitch_count", n_ded, 0);
    clr_stats();
    p = t;
    repeat (2) step(1, 0, 0, 1);
    step(1, 1, 0, 1);
    repeat (10) step(1, 0, 0, 1);
    repeat (12) step(1, 1, 0, 1);
    chk("bounce_edge", first_ded - p, 8);
    chk("bounce_count", n_ded, AR ? 2 : 1);

    // both pressed together, then add alone
    clr_stats();
    repeat (20) step(0, 0, 0, 1);
    repeat (12) step(1, 1, 0, 1);
    chk("both_count", n_add + n_ded, 0);
    clr_stats();
    p = t;
    repeat (10) step(0, 1, 0, 1);
    repeat (12) step(1, 1, 0, 1);
    chk("after_both_edge", first_add - p, 5);
    chk("after_both_count", n_add, AR ? 2 : 1);

    // reset mid-debounce
    clr_stats();
    repeat (4) step(0, 1, 0, 1);
    repeat (2) step(0, 1, 0, 0);
    rr = t;
    repeat (7) step(0, 1, 0, 1);
    repeat (12) step(1, 1, 0, 1);
    chk("rst_mid_edge", first_add - rr, 5);
    chk("rst_mid_count", n_add, 1);

    // long hold
    clr_stats();
    p = t;
    repeat (30) step(0, 1, 0, 1);
    repeat (12) step(1, 1, 0, 1);
    chk("hold_edge", first_add - p, 5);
    chk("hold_count", n_add, AR ? 9 : 1);

    // mode switch level
    repeat (10) step(1, 1, 1, 1);
    chk("mode_on", bus.mode_out, 1);
    repeat (10) step(1, 1, 0, 1);
    chk("mode_off", bus.mode_out, 0);

    // random bouncing inputs with occasional reset
    for (int i = 0; i < 3; i++) begin
      run[i] = 0;
      cur[i] = 1'b1;
    end
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (run[i] == 0) begin
          cur[i] = 1'($urandom_range(0, 1));
          run[i] = $urandom_range(1, 14);
        end
        run[i]--;
      end
      step(cur[0], cur[1], cur[2], $urandom_range(0, 299) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
